branch_sequencer: RTL and testbench

//  - Sequences the PC register and drives the 2-bit select of Branching_MUX.
//  - Per instruction: accepts decoded branch info from decode via a valid/ready handshake.
//  - Resolves the branch condition against the ALU flags.
//  - Then loads the PC from the mux output (pc+4, imm target, or reg target).
//  - Sits between decode/flags and the fetch PC; the only writer of the PC.

---
 rtl/branch_sequencer.sv | 110 +++++++++++
 tb/tb_branch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC sequencer and Branching_MUX select driver, the sole writer of the PC.
// Optional taken-branch counter enabled by defining BRANCH_CNT_EN.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        branch_type,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              halt,
  input  logic              stall,
  input  logic [31:0]       next_addr,
  output logic [31:0]       pc,
  output logic [31:0]       pc_add,
  output logic [1:0]        branch_control_out,
  output logic              pc_valid,
  output logic              taken,
  output logic              flush,
  output logic              halted
`ifdef BRANCH_CNT_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt
`endif
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_HALT   = 2'd2;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_REG = 2'b10;

  logic [1:0] state;
  logic       halt_q;
  logic [1:0] sel_next;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  assign pc_add      = pc + 32'(PC_STEP);
  assign pc_valid    = (state == S_FETCH);
  assign instr_ready = (state == S_FETCH) && !stall;
  assign halted      = (state == S_HALT);
  assign taken       = (state == S_UPDATE) && (branch_control_out != SEL_SEQ);
  assign flush       = taken;

  // Condition resolution against the flags presented alongside the instruction.
  always_comb begin
    sel_next = SEL_SEQ;
    case (branch_type)
      3'b001:  sel_next = SEL_IMM;
      3'b010:  sel_next = SEL_REG;
      3'b011:  sel_next = flag_zero  ? SEL_IMM : SEL_SEQ;
      3'b100:  sel_next = !flag_zero ? SEL_IMM : SEL_SEQ;
      3'b101:  sel_next = flag_sign  ? SEL_IMM : SEL_SEQ;
      3'b110:  sel_next = flag_carry ? SEL_IMM : SEL_SEQ;
      default: sel_next = SEL_SEQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc                 <= RESET_PC;
      state              <= S_FETCH;
      branch_control_out <= SEL_SEQ;
      halt_q             <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid && !stall) begin
            branch_control_out <= sel_next;
            halt_q             <= halt;
            state              <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // The select was held all cycle, so next_addr reflects the resolved target.
          pc                 <= next_addr;
          branch_control_out <= SEL_SEQ;
          state              <= halt_q ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef BRANCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      taken_cnt <= '0;
    end else if (taken && (taken_cnt != {CNT_W{1'b1}})) begin
      taken_cnt <= taken_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed bench for branch_sequencer with a cycle-level reference model.
module tb_branch_sequencer;

  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  branch_type = 3'd0;
  logic        flag_zero = 1'b0;
  logic        flag_sign = 1'b0;
  logic        flag_carry = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] next_addr;
  logic [31:0] pc;
  logic [31:0] pc_add;
  logic [1:0]  branch_control_out;
  logic        pc_valid;
  logic        taken;
  logic        flush;
  logic        halted;
`ifdef BRANCH_CNT_EN
  logic [CNT_W-1:0] taken_cnt;
`endif

  logic [31:0] imm_tgt = 32'h0;
  logic [31:0] reg_tgt = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  int taken_seen = 0;

  always #5 clk = ~clk;

  // External Branching_MUX
  assign next_addr = (branch_control_out == 2'b01) ? imm_tgt :
                     (branch_control_out == 2'b10) ? reg_tgt : pc_add;

  branch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .branch_type       (branch_type),
    .flag_zero         (flag_zero),
    .flag_sign         (flag_sign),
    .flag_carry        (flag_carry),
    .halt              (halt),
    .stall             (stall),
    .next_addr         (next_addr),
    .pc                (pc),
    .pc_add            (pc_add),
    .branch_control_out(branch_control_out),
    .pc_valid          (pc_valid),
    .taken             (taken),
    .flush             (flush),
    .halted            (halted)
`ifdef BRANCH_CNT_EN
    ,
    .taken_cnt         (taken_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] expected_sel(input logic [2:0] t, input logic z, input logic s, input logic c);
    case (t)
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return z  ? 2'd1 : 2'd0;
      3'd4:    return !z ? 2'd1 : 2'd0;
      3'd5:    return s  ? 2'd1 : 2'd0;
      3'd6:    return c  ? 2'd1 : 2'd0;
      default: return 2'd0;
    endcase
  endfunction

  // Reference model: one instruction is "pending" between acceptance and the PC load.
  logic [31:0] m_pc = 32'h0;
  logic [1:0]  m_sel = 2'd0;
  bit          m_pending = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_halt_req = 1'b0;
  bit          m_ok = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc <= 32'h0; m_sel <= 2'd0; m_pending <= 1'b0; m_halt <= 1'b0;
      m_halt_req <= 1'b0; m_cnt <= 0; m_ok <= 1'b1;
    end else if (m_ok && !m_halt) begin
      if (m_pending) begin
        m_pc      <= (m_sel == 2'd1) ? imm_tgt : (m_sel == 2'd2) ? reg_tgt : m_pc + 32'd4;
        m_sel     <= 2'd0;
        m_pending <= 1'b0;
        m_halt    <= m_halt_req;
        if (m_sel != 2'd0 && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
      end else if (instr_valid && !stall) begin
        m_sel      <= expected_sel(branch_type, flag_zero, flag_sign, flag_carry);
        m_halt_req <= halt;
        m_pending  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("pc", pc, m_pc);
      chk("pc_add", pc_add, m_pc + 32'd4);
      chk("sel", 32'(branch_control_out), 32'(m_sel));
      chk("pc_valid", 32'(pc_valid), 32'(!m_pending && !m_halt));
      chk("instr_ready", 32'(instr_ready), 32'(!m_pending && !m_halt && !stall));
      chk("taken", 32'(taken), 32'(m_pending && m_sel != 2'd0));
      chk("flush", 32'(flush), 32'(m_pending && m_sel != 2'd0));
      chk("halted", 32'(halted), 32'(m_halt));
`ifdef BRANCH_CNT_EN
      chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
`endif
      if (taken) taken_seen++;
    end
  end

  task automatic issue(input logic [2:0] t, input logic z, input logic s, input logic c,
                       input logic h, input logic [31:0] imm, input logic [31:0] rg);
    bit ok;
    ok = 1'b0;
    branch_type = t; flag_zero = z; flag_sign = s; flag_carry = c; halt = h;
    imm_tgt = imm; reg_tgt = rg; instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    instr_valid = 1'b0; halt = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    int t0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_sel", 32'(branch_control_out), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    @(posedge clk); #2;

    // Sequential flow
    t0 = taken_seen;
    for (int i = 0; i < 3; i++) issue(3'd0, 0, 0, 0, 0, 32'hDEAD_0000, 32'hBEEF_0000);
    chk("seq_pc", pc, 32'd12);
    chk("seq_no_taken", 32'(taken_seen - t0), 32'd0);

    // Immediate jump, one taken pulse
    t0 = taken_seen;
    issue(3'd1, 0, 0, 0, 0, 32'h40, 32'h0);
    chk("jmp_imm_pc", pc, 32'h40);
    chk("jmp_imm_pulses", 32'(taken_seen - t0), 32'd1);

    // Conditional branches
    issue(3'd3, 1, 0, 0, 0, 32'h100, 32'h0);
    chk("bz_taken_pc", pc, 32'h100);
    issue(3'd3, 0, 0, 0, 0, 32'h300, 32'h0);
    chk("bz_not_pc", pc, 32'h104);
    issue(3'd4, 0, 0, 0, 0, 32'h140, 32'h0);
    chk("bnz_taken_pc", pc, 32'h140);
    issue(3'd5, 0, 0, 0, 0, 32'h900, 32'h0);
    chk("bneg_not_pc", pc, 32'h144);
    issue(3'd6, 0, 0, 1, 0, 32'h180, 32'h0);
    chk("bcarry_taken_pc", pc, 32'h180);
    issue(3'd7, 1, 1, 1, 0, 32'h999, 32'h777);
    chk("rsvd_pc", pc, 32'h184);
    issue(3'd4, 1, 0, 0, 0, 32'h500, 32'h0);
    chk("bnz_not_pc", pc, 32'h188);
    issue(3'd5, 0, 1, 0, 0, 32'h1C0, 32'h0);
    chk("bneg_taken_pc", pc, 32'h1C0);
    issue(3'd2, 0, 0, 0, 0, 32'h0, 32'h60);
    chk("jmp_reg_pc", pc, 32'h60);

    // Stall holds FETCH
    stall = 1'b1; branch_type = 3'd1; imm_tgt = 32'h200; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(instr_ready), 32'd0);
      chk("stall_pc", pc, 32'h60);
    end
    @(posedge clk); #2 stall = 1'b0;
    issue(3'd1, 0, 0, 0, 0, 32'h200, 32'h0);
    chk("after_stall_pc", pc, 32'h200);

    // PC wraparound
    issue(3'd1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk);
    chk("wrap_pc_add", pc_add, 32'h0);
    @(posedge clk); #2;
    issue(3'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Reset during UPDATE
    issue(3'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    branch_type = 3'd1; imm_tgt = 32'h500; instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    instr_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("upd_rst_pc", pc, 32'h0);
    chk("upd_rst_taken", 32'(taken), 32'd0);
    chk("upd_rst_pc_valid", 32'(pc_valid), 32'd1);
    @(posedge clk); #2;

`ifdef BRANCH_CNT_EN
    for (int i = 1; i <= 5; i++) issue(3'd1, 0, 0, 0, 0, 32'(i * 16), 32'h0);
    chk("cnt_saturated", 32'(taken_cnt), 32'd3);
`endif

    // Halt together with a taken register jump
    issue(3'd2, 0, 0, 0, 1, 32'h0, 32'h80);
    chk("halt_pc", pc, 32'h80);
    chk("halt_flag", 32'(halted), 32'd1);
    instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_frozen_pc", pc, 32'h80);
      chk("halt_pc_valid", 32'(pc_valid), 32'd0);
    end
    instr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
